// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: March element orders and
// address sequencer state encoding.
package mbist_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } st_e;

endpackage

// File: rtl/march_addr_gen_if.sv
// Controller <-> address sequencer bundle.
// master = March controller, slave = address generator.
interface march_addr_gen_if #(
  parameter int ADDR_W = 7
) ();

  logic              MBISTEN;
  logic              START;
  logic [1:0]        MODE;
  logic              STEP;
  logic [ADDR_W-1:0] ADDR;
  logic              ADDR_VALID;
  logic              ADDR_LAST;
  logic              ADDR_DONE;
  logic              BUSY;

  modport master (
    output MBISTEN,
    output START,
    output MODE,
    output STEP,
    input  ADDR,
    input  ADDR_VALID,
    input  ADDR_LAST,
    input  ADDR_DONE,
    input  BUSY
  );

  modport slave (
    input  MBISTEN,
    input  START,
    input  MODE,
    input  STEP,
    output ADDR,
    output ADDR_VALID,
    output ADDR_LAST,
    output ADDR_DONE,
    output BUSY
  );

endinterface

// File: rtl/march_addr_gen.sv
// March element address sequencer: up, down or ping-pong
// order over DEPTH words, one address per STEP handshake.
module march_addr_gen
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input logic           CLK,
  input logic           RESET,
  march_addr_gen_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   C_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   C_END  = (ADDR_W + 1)'(DEPTH);

  st_e               state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic              pick_hi_q, pick_hi_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Next address for the latched order; ping-pong alternates
  // between the low and high pointers, MODE 11 counts up.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [1:0]        md,
    input logic [ADDR_W-1:0] cur,
    input logic [ADDR_W-1:0] lo,
    input logic [ADDR_W-1:0] hi,
    input logic              take_hi
  );
    logic [ADDR_W-1:0] nxt;
    nxt = cur + A_ONE;
    unique case (1'b1)
      (md == MODE_DOWN):     nxt = cur - A_ONE;
      (md == MODE_PINGPONG): nxt = take_hi ? hi : lo;
      default:               nxt = cur + A_ONE;
    endcase
    return nxt;
  endfunction

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_UP;
      addr_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      pick_hi_q <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      pick_hi_q <= pick_hi_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output computation; enable drop aborts
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    pick_hi_d = pick_hi_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d   = ST_RUN;
          mode_d    = bus.MODE;
          addr_d    = (bus.MODE == MODE_DOWN) ? A_LAST : '0;
          lo_d      = A_ONE;
          hi_d      = A_LAST;
          pick_hi_d = 1'b1;
          cnt_d     = C_ONE;
          valid_d   = 1'b1;
          last_d    = (C_ONE == C_END);
          busy_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.STEP) begin
          if (cnt_q == C_END) begin
            state_d = ST_FIN;
            addr_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = next_addr(mode_q, addr_q,
                               lo_q, hi_q, pick_hi_q);
            cnt_d  = cnt_q + C_ONE;
            last_d = ((cnt_q + C_ONE) == C_END);
            if (mode_q == MODE_PINGPONG) begin
              pick_hi_d = ~pick_hi_q;
              if (pick_hi_q) hi_d = hi_q - A_ONE;
              else           lo_d = lo_q + A_ONE;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (!bus.MBISTEN) begin
      state_d   = ST_IDLE;
      mode_d    = MODE_UP;
      addr_d    = '0;
      lo_d      = '0;
      hi_d      = '0;
      pick_hi_d = 1'b0;
      cnt_d     = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.ADDR       = addr_q;
    bus.ADDR_VALID = valid_q;
    bus.ADDR_LAST  = last_q;
    bus.ADDR_DONE  = done_q;
    bus.BUSY       = busy_q;
  end

endmodule

// File: tb/tb_march_addr_gen.sv
// Bench for march_addr_gen: three depths, random STEP
// spacing, checked against an arithmetic order model.
module tb_march_addr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en    [3];
  logic       start [3];
  logic       step  [3];
  logic [1:0] mode  [3];
  logic [7:0] ao    [3];
  logic       vo    [3];
  logic       lo    [3];
  logic       dn    [3];
  logic       bo    [3];

  int checks = 0;
  int errors = 0;

  march_addr_gen_if #(.ADDR_W(7)) if0 ();
  march_addr_gen_if #(.ADDR_W(3)) if1 ();
  march_addr_gen_if #(.ADDR_W(3)) if2 ();

  assign if0.MBISTEN = en[0];
  assign if0.START   = start[0];
  assign if0.STEP    = step[0];
  assign if0.MODE    = mode[0];
  assign if1.MBISTEN = en[1];
  assign if1.START   = start[1];
  assign if1.STEP    = step[1];
  assign if1.MODE    = mode[1];
  assign if2.MBISTEN = en[2];
  assign if2.START   = start[2];
  assign if2.STEP    = step[2];
  assign if2.MODE    = mode[2];

  assign ao[0] = {1'b0, if0.ADDR};
  assign ao[1] = {5'b0, if1.ADDR};
  assign ao[2] = {5'b0, if2.ADDR};
  assign vo[0] = if0.ADDR_VALID;
  assign vo[1] = if1.ADDR_VALID;
  assign vo[2] = if2.ADDR_VALID;
  assign lo[0] = if0.ADDR_LAST;
  assign lo[1] = if1.ADDR_LAST;
  assign lo[2] = if2.ADDR_LAST;
  assign dn[0] = if0.ADDR_DONE;
  assign dn[1] = if1.ADDR_DONE;
  assign dn[2] = if2.ADDR_DONE;
  assign bo[0] = if0.BUSY;
  assign bo[1] = if1.BUSY;
  assign bo[2] = if2.BUSY;

  march_addr_gen #(.ADDR_W(7), .DEPTH(128)) u0 (
    .CLK(clk), .RESET(rst), .bus(if0)
  );
  march_addr_gen #(.ADDR_W(3), .DEPTH(5)) u1 (
    .CLK(clk), .RESET(rst), .bus(if1)
  );
  march_addr_gen #(.ADDR_W(3), .DEPTH(6)) u2 (
    .CLK(clk), .RESET(rst), .bus(if2)
  );

  int dep [3] = '{128, 5, 6};

  // i-th address of an element sequence, from the order rules
  function automatic int exp_addr(int md, int d, int i);
    if (md == 1) return d - 1 - i;
    if (md == 2) return (i % 2 == 0) ? i / 2 : d - 1 - i / 2;
    return i;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input int k, input string tag,
                         input int a, input int v,
                         input int l, input int d,
                         input int b);
    chk($sformatf("%s.u%0d.addr", tag, k), 32'(ao[k]), a);
    chk($sformatf("%s.u%0d.valid", tag, k), 32'(vo[k]), v);
    chk($sformatf("%s.u%0d.last", tag, k), 32'(lo[k]), l);
    chk($sformatf("%s.u%0d.done", tag, k), 32'(dn[k]), d);
    chk($sformatf("%s.u%0d.busy", tag, k), 32'(bo[k]), b);
  endtask

  task automatic run_seq(input int k, input int md,
                         input int gmin, input int gmax,
                         input int abort_at);
    int d;
    int q[$];
    int g;
    int em;
    d = dep[k];
    em = (md == 3) ? 0 : md;
    q.delete();
    for (int i = 0; i < d; i++) q.push_back(exp_addr(em, d, i));
    @(negedge clk);
    en[k] = 1'b1;
    start[k] = 1'b1;
    mode[k] = 2'(md);
    step[k] = 1'b0;
    @(negedge clk);
    start[k] = 1'b0;
    mode[k] = 2'($urandom_range(0, 3));
    chk_out(k, "first", q[0], 1, 0, 0, 1);
    for (int i = 0; i < d; i++) begin
      g = $urandom_range(gmin, gmax);
      for (int c = 0; c < g; c++) begin
        step[k] = 1'b0;
        start[k] = 1'($urandom_range(0, 1));
        mode[k] = 2'($urandom_range(0, 3));
        @(negedge clk);
        chk_out(k, "hold", q[i], 1, (i == d - 1) ? 1 : 0, 0, 1);
      end
      start[k] = 1'b0;
      step[k] = 1'b1;
      if (i == abort_at) begin
        en[k] = 1'b0;
        @(negedge clk);
        step[k] = 1'b0;
        chk_out(k, "abort", 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out(k, "abort2", 0, 0, 0, 0, 0);
        en[k] = 1'b1;
        return;
      end
      @(negedge clk);
      if (i < d - 1) begin
        chk_out(k, "adv", q[i + 1], 1,
                (i + 1 == d - 1) ? 1 : 0, 0, 1);
      end else begin
        step[k] = 1'b0;
        start[k] = 1'b1;
        chk_out(k, "fin", 0, 0, 0, 1, 1);
      end
    end
    @(negedge clk);
    start[k] = 1'b0;
    chk_out(k, "idle", 0, 0, 0, 0, 0);
  endtask

  task automatic idle_step(input int k);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      step[k] = 1'b1;
      @(negedge clk);
      chk_out(k, "istep", 0, 0, 0, 0, 0);
    end
    step[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b1;
      start[k] = 1'b0;
      step[k] = 1'b0;
      mode[k] = 2'b00;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) start[k] = ~start[k];
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk_out(k, "rst", 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    rst = 1'b0;

    run_seq(0, 0, 0, 0, -1);
    run_seq(1, 1, 2, 2, -1);
    run_seq(1, 2, 0, 3, -1);
    run_seq(2, 2, 0, 2, -1);
    run_seq(0, 0, 0, 1, 37);
    run_seq(0, 0, 0, 2, -1);
    idle_step(0);
    idle_step(1);
    idle_step(2);
    run_seq(2, 3, 0, 1, -1);
    run_seq(1, 3, 0, 2, -1);
    for (int r = 0; r < 8; r++) begin
      run_seq(int'($urandom_range(1, 2)),
              int'($urandom_range(0, 3)), 0, 3, -1);
    end
    run_seq(1, 1, 0, 1, int'($urandom_range(0, 4)));
    run_seq(1, 1, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
